// File: rtl/clock_set_ctrl_if.sv
// Load bus from the edit sequencer to the timekeeping / alarm registers.
//   ld_hour, ld_min, ld_sec : one-cycle field load strobes (mutually exclusive)
//   ld_target               : 0 = timekeeping registers, 1 = alarm registers
//   ld_val                  : clamped binary field value
//   ld_bcd_h / ld_bcd_l     : ld_val / 10 and ld_val % 10
// master = sequencer (drives), slave = register bank (receives).
interface clock_set_ctrl_if;
  logic       ld_hour;
  logic       ld_min;
  logic       ld_sec;
  logic       ld_target;
  logic [5:0] ld_val;
  logic [3:0] ld_bcd_h;
  logic [3:0] ld_bcd_l;

  modport master (
    output ld_hour, ld_min, ld_sec, ld_target, ld_val, ld_bcd_h, ld_bcd_l
  );

  modport slave (
    input  ld_hour, ld_min, ld_sec, ld_target, ld_val, ld_bcd_h, ld_bcd_l
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Edit-mode sequencer for the digital clock.
// Debounces the time-set and alarm-set buttons, walks the hour/minute/second
// edit menus, clamps and BCD-splits the switch value and commits each field
// through one-cycle load strobes. Also drives display freeze/blank/LED hints.
//   clk, clr        : system clock, asynchronous active-low reset
//   tick_1hz        : one-cycle pulse per second (edit timeout base)
//   btn_time        : raw time-set button
//   btn_alarm       : raw alarm-set button
//   sw[5:0]         : raw binary field value from switches
//   state[2:0]      : RUN=0 T_HOUR=1 T_MIN=2 T_SEC=3 A_HOUR=4 A_MIN=5 A_SEC=6
//   ld              : load bus (see clock_set_ctrl_if)
//   run_en          : timekeeping may advance (low while editing the time)
//   blank_mask[3:0] : bit i blanks 7-segment digit i (digit 0 = seconds low)
//   edit_led[5:0]   : clamped live switch value while editing, 0 in RUN
module clock_set_ctrl #(
  parameter int unsigned CLK_HZ       = 125000000,
  parameter int unsigned DEBOUNCE_CYC = 1250000,
  parameter int unsigned TIMEOUT_S    = 30
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    tick_1hz,
  input  logic                    btn_time,
  input  logic                    btn_alarm,
  input  logic [5:0]              sw,
  output logic [2:0]              state,
  clock_set_ctrl_if.master        ld,
  output logic                    run_en,
  output logic [3:0]              blank_mask,
  output logic [5:0]              edit_led
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_S + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    T_HOUR = 3'd1,
    T_MIN  = 3'd2,
    T_SEC  = 3'd3,
    A_HOUR = 3'd4,
    A_MIN  = 3'd5,
    A_SEC  = 3'd6
  } st_t;

  st_t st, nxt;

  // ---------------------------------------------------------------------
  // Button conditioning: bit 0 = time button, bit 1 = alarm button.
  // ---------------------------------------------------------------------
  logic [1:0]      raw;
  logic [1:0]      sync1, sync2;
  logic [1:0]      level, level_d;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;

  assign raw = {btn_alarm, btn_time};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          // this is the DEBOUNCE_CYC-th consecutive differing cycle
          db_cnt[i] <= '0;
          level[i]  <= ~level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = level & ~level_d;

  // ---------------------------------------------------------------------
  // Field helpers
  // ---------------------------------------------------------------------
  function automatic logic is_hour(input st_t s);
    return (s == T_HOUR) || (s == A_HOUR);
  endfunction

  function automatic logic is_min(input st_t s);
    return (s == T_MIN) || (s == A_MIN);
  endfunction

  function automatic logic is_sec(input st_t s);
    return (s == T_SEC) || (s == A_SEC);
  endfunction

  function automatic logic is_time_edit(input st_t s);
    return (s == T_HOUR) || (s == T_MIN) || (s == T_SEC);
  endfunction

  function automatic logic [5:0] clamp(input st_t s, input logic [5:0] v);
    logic [5:0] lim;
    lim = is_hour(s) ? 6'd23 : 6'd59;
    return (v > lim) ? lim : v;
  endfunction

  // Value committed when leaving the current field
  logic [5:0] cv;
  logic [5:0] cv_q, cv_r;

  assign cv   = clamp(st, sw);
  assign cv_q = cv / 6'd10;
  assign cv_r = cv % 6'd10;

  // ---------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------
  logic [TO_W-1:0] to_cnt;
  logic            accept;
  logic            timeout;
  logic            commit;

  always_comb begin
    nxt    = st;
    accept = 1'b0;
    case (st)
      RUN: begin
        // time button wins if both land in the same cycle
        if (press[0]) begin
          nxt    = T_HOUR;
          accept = 1'b1;
        end else if (press[1]) begin
          nxt    = A_HOUR;
          accept = 1'b1;
        end
      end
      T_HOUR: if (press[0]) begin nxt = T_MIN;  accept = 1'b1; end
      T_MIN:  if (press[0]) begin nxt = T_SEC;  accept = 1'b1; end
      T_SEC:  if (press[0]) begin nxt = RUN;    accept = 1'b1; end
      A_HOUR: if (press[1]) begin nxt = A_MIN;  accept = 1'b1; end
      A_MIN:  if (press[1]) begin nxt = A_SEC;  accept = 1'b1; end
      A_SEC:  if (press[1]) begin nxt = RUN;    accept = 1'b1; end
      default: nxt = RUN;
    endcase
    // a press in the same cycle as the final tick takes priority
    timeout = (st != RUN) && !accept && tick_1hz && (to_cnt == TO_LAST);
    if (timeout) nxt = RUN;
  end

  assign commit = accept && (st != RUN);

  // ---------------------------------------------------------------------
  // State, timeout counter and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st           <= RUN;
      to_cnt       <= '0;
      ld.ld_hour   <= 1'b0;
      ld.ld_min    <= 1'b0;
      ld.ld_sec    <= 1'b0;
      ld.ld_target <= 1'b0;
      ld.ld_val    <= '0;
      ld.ld_bcd_h  <= '0;
      ld.ld_bcd_l  <= '0;
      run_en       <= 1'b1;
      blank_mask   <= '0;
      edit_led     <= '0;
    end else begin
      st <= nxt;

      if (accept || nxt == RUN) to_cnt <= '0;
      else if (tick_1hz)        to_cnt <= to_cnt + 1'b1;

      ld.ld_hour <= commit && is_hour(st);
      ld.ld_min  <= commit && is_min(st);
      ld.ld_sec  <= commit && is_sec(st);
      if (commit) begin
        ld.ld_target <= !is_time_edit(st);
        ld.ld_val    <= cv;
        ld.ld_bcd_h  <= cv_q[3:0];
        ld.ld_bcd_l  <= cv_r[3:0];
      end

      // display hints follow the state being entered so they line up with it
      run_en <= !is_time_edit(nxt);
      if (nxt == RUN)       blank_mask <= 4'b0000;
      else if (is_hour(nxt)) blank_mask <= 4'b1111;
      else if (is_min(nxt))  blank_mask <= 4'b0011;
      else                   blank_mask <= 4'b1100;
      edit_led <= (nxt == RUN) ? 6'd0 : clamp(nxt, sw);
    end
  end

  assign state = st;

endmodule
